// File: rtl/wave_table_loader.sv
// wave_table_loader: streams samples into the sine/triangle BRAM region; define WAVE_TABLE_CHECKSUM_EN for the running checksum
module wave_table_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] SINE_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] SINE_LAST = 16'h03FF,
  parameter logic [ADDR_W-1:0] TRI_BASE = 16'h0400,
  parameter logic [ADDR_W-1:0] TRI_LAST = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        tbl_sel,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_dout,
  output logic              bram_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_written,
  output logic [15:0]       checksum
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr, last;
  logic xfer, legal;
  assign legal = start && !tbl_sel[1];
  assign xfer = s_valid && s_ready;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: abort beats a coinciding sample; the transfer at last ends the load
  always_comb
    state_nx = state == IDLE ? (legal ? LOAD : IDLE) :
               state == LOAD ? (abort ? IDLE : (xfer && ptr == last) ? DONE : LOAD) : IDLE;
  // handshake and status outputs decoded from state
  always_comb begin
    busy = state == LOAD;
    done = state == DONE;
    s_ready = busy && !abort;
  end
  // registered BRAM write, pointer/limit, word count and sticky error
  always_ff @(posedge clk)
    if (rst) begin
      ptr <= '0;
      last <= '0;
      words_written <= '0;
      err <= 1'b0;
      bram_we <= 1'b0;
      bram_addr <= '0;
      bram_dout <= '0;
    end else begin
      bram_we <= xfer;
      if (xfer) begin
        bram_addr <= ptr;
        bram_dout <= s_data;
        words_written <= words_written + ADDR_W'(1);
        if (ptr != last) ptr <= ptr + ADDR_W'(1);
      end
      if (state == IDLE && start) begin
        err <= !legal;
        if (legal) begin
          ptr <= tbl_sel[0] ? TRI_BASE : SINE_BASE;
          last <= tbl_sel[0] ? TRI_LAST : SINE_LAST;
          words_written <= '0;
        end
      end
      if (state == LOAD && abort) err <= 1'b1;
    end
`ifdef WAVE_TABLE_CHECKSUM_EN
  // modulo-2^16 sum of accepted samples, cleared by a legal start
  always_ff @(posedge clk)
    if (rst) checksum <= '0;
    else if (state == IDLE && legal) checksum <= '0;
    else if (xfer) checksum <= checksum + 16'(s_data);
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_wave_table_loader.sv
// tb_wave_table_loader: scoreboard bench for wave_table_loader
module tb_wave_table_loader;
  logic clk = 0, rst = 1, start = 0, abort = 0, s_valid = 0;
  logic [1:0] tbl_sel = 0;
  logic [7:0] s_data = 0;
  logic s_ready, bram_we, busy, done, err;
  logic [15:0] bram_addr, words_written, checksum;
  logic [7:0] bram_dout;
  logic [23:0] exp_q[$];
  int checks = 0, errors = 0, done_cnt = 0;
  logic [15:0] sum = 0;

  wave_table_loader dut (
    .clk(clk), .rst(rst), .start(start), .tbl_sel(tbl_sel), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .bram_we(bram_we), .busy(busy), .done(done), .err(err),
    .words_written(words_written), .checksum(checksum));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_ck();
`ifdef WAVE_TABLE_CHECKSUM_EN
    return sum;
`else
    return 16'h0;
`endif
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bram_we) begin
      if (exp_q.size() == 0) check("spurious_we", {bram_addr, bram_dout}, 24'hFFFFFF);
      else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("we_addr", bram_addr, e[23:8]);
        check("we_data", bram_dout, e[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] t);
    start = 1;
    tbl_sel = t;
    tick();
    start = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic [15:0] a, input bit gap);
    if (gap) begin
      s_valid = 0;
      tick();
    end
    s_valid = 1;
    s_data = d;
    @(negedge clk);
    #1;
    check("s_ready", s_ready, 1);
    exp_q.push_back({a, d});
    sum = sum + 16'(d);
    tick();
    s_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {s_ready, busy, done, err, bram_we}, 5'b0);
    check("rst_addr", bram_addr, 0);
    check("rst_dout", bram_dout, 0);
    check("rst_ww", words_written, 0);
    check("rst_ck", checksum, 0);
    rst = 0;
    tick();
    // sine load, continuous valid
    done_cnt = 0;
    sum = 0;
    pulse_start(0);
    check("sine_busy", busy, 1);
    for (int i = 0; i < 1024; i++) send(8'(i), 16'(i), 0);
    check("sine_done", done, 1);
    check("sine_ready_off", s_ready, 0);
    tick();
    check("sine_done_one", {done, busy}, 2'b00);
    check("sine_done_cnt", done_cnt, 1);
    check("sine_ww", words_written, 1024);
    check("sine_ck", checksum, exp_ck());
    check("sine_q_empty", exp_q.size(), 0);
    // triangle load, toggling valid, stray start mid-load
    done_cnt = 0;
    sum = 0;
    pulse_start(1);
    for (int i = 0; i < 1025; i++) begin
      if (i == 300) begin
        s_valid = 0;
        start = 1;
        tbl_sel = 0;
        tick();
        start = 0;
      end
      send(8'hAA, 16'h0400 + 16'(i), 1);
    end
    check("tri_done", done, 1);
    repeat (3) tick();
    check("tri_busy_off", busy, 0);
    check("tri_done_cnt", done_cnt, 1);
    check("tri_ww", words_written, 1025);
    check("tri_ck", checksum, exp_ck());
    check("tri_q_empty", exp_q.size(), 0);
    // illegal table select then legal start
    pulse_start(3);
    check("ill_err", err, 1);
    check("ill_busy", busy, 0);
    tick();
    check("ill_stay_idle", busy, 0);
    done_cnt = 0;
    sum = 0;
    pulse_start(0);
    check("legal_clr_err", err, 0);
    check("legal_ww_clr", words_written, 0);
    // abort with coinciding sample after 10 samples
    for (int i = 0; i < 10; i++) send(8'(i + 7), 16'(i), 0);
    abort = 1;
    s_valid = 1;
    s_data = 8'h55;
    @(negedge clk);
    #1;
    check("abort_ready", s_ready, 0);
    tick();
    abort = 0;
    s_valid = 0;
    check("abort_err", err, 1);
    check("abort_busy", busy, 0);
    check("abort_ww", words_written, 10);
    repeat (3) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_ck", checksum, exp_ck());
    check("abort_q_empty", exp_q.size(), 0);
    // reset mid-load at sample 500
    pulse_start(0);
    for (int i = 0; i < 500; i++) send(8'(i ^ 8'h3C), 16'(i), 0);
    rst = 1;
    s_valid = 1;
    s_data = 8'hEE;
    tick();
    s_valid = 0;
    check("rst_we", bram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_ww2", words_written, 0);
    rst = 0;
    tick();
    sum = 0;
    pulse_start(0);
    for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), 16'(i), 0);
    check("restart_ww", words_written, 3);
    check("restart_ck", checksum, exp_ck());
    abort = 1;
    tick();
    abort = 0;
    repeat (2) tick();
    check("final_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
